// File: rtl/draw_scheduler.sv
// Write-side controller for the 1-bit draw framebuffer: full-frame clears and
// per-particle plots share one write port, with clears taking priority.
module draw_scheduler #(
    parameter int unsigned DRAW_WIDTH  = 640,
    parameter int unsigned DRAW_HEIGHT = 480,
    parameter int unsigned DRAW_SIZE   = DRAW_WIDTH * DRAW_HEIGHT,
    parameter int unsigned DRAW_ADDRW  = $clog2(DRAW_SIZE),
    parameter int unsigned DRAW_DATAW  = 1,
    parameter int unsigned COORD_W     = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  clear_done,
    output logic                  busy,
    input  logic                  plot_valid,
    output logic                  plot_ready,
    input  logic [COORD_W-1:0]    plot_x,
    input  logic [COORD_W-1:0]    plot_y,
    input  logic [DRAW_DATAW-1:0] plot_color,
    output logic [DRAW_ADDRW-1:0] draw_addr_write,
    output logic [DRAW_DATAW-1:0] draw_data_in,
    output logic                  draw_we,
    output logic [15:0]           drop_count
);

    localparam logic [DRAW_ADDRW-1:0] LAST_ADDR = DRAW_ADDRW'(DRAW_SIZE - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    logic [DRAW_ADDRW-1:0]   sweep;
    logic                    plot_in_range;
    logic [DRAW_ADDRW-1:0]   plot_addr;

    // A pending clear blocks the handshake in the same cycle, so clears win.
    assign plot_ready    = (state == IDLE) && !clear_req;
    assign plot_in_range = (32'(plot_x) < DRAW_WIDTH) && (32'(plot_y) < DRAW_HEIGHT);
    assign plot_addr     = DRAW_ADDRW'(32'(plot_y) * DRAW_WIDTH + 32'(plot_x));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            sweep           <= '0;
            draw_we         <= 1'b0;
            draw_addr_write <= '0;
            draw_data_in    <= '0;
            clear_done      <= 1'b0;
            busy            <= 1'b0;
            drop_count      <= '0;
        end else begin
            draw_we    <= 1'b0;
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        // First sweep write (address 0) goes out with the state change.
                        state           <= CLEAR;
                        busy            <= 1'b1;
                        sweep           <= '0;
                        draw_we         <= 1'b1;
                        draw_addr_write <= '0;
                        draw_data_in    <= '0;
                    end else if (plot_valid) begin
                        if (plot_in_range) begin
                            draw_we         <= 1'b1;
                            draw_addr_write <= plot_addr;
                            draw_data_in    <= plot_color;
                        end else if (drop_count != 16'hFFFF) begin
                            drop_count <= drop_count + 16'd1;
                        end
                    end
                end
                CLEAR: begin
                    if (sweep == LAST_ADDR) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        sweep           <= sweep + DRAW_ADDRW'(1);
                        draw_we         <= 1'b1;
                        draw_addr_write <= sweep + DRAW_ADDRW'(1);
                        draw_data_in    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler on an 8x4 framebuffer: a cycle-indexed
// write schedule model plus directed literal checks and a randomized plot stream.
module tb_draw_scheduler;

    localparam int unsigned W    = 8;
    localparam int unsigned H    = 4;
    localparam int unsigned SIZE = W * H;
    localparam int unsigned AW   = $clog2(SIZE);
    localparam int unsigned CW   = 10;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          clear_req  = 1'b0;
    logic          plot_valid = 1'b0;
    logic [CW-1:0] plot_x     = '0;
    logic [CW-1:0] plot_y     = '0;
    logic          plot_color = 1'b0;
    logic          clear_done;
    logic          busy;
    logic          plot_ready;
    logic [AW-1:0] draw_addr_write;
    logic          draw_data_in;
    logic          draw_we;
    logic [15:0]   drop_count;

    draw_scheduler #(
        .DRAW_WIDTH (W),
        .DRAW_HEIGHT(H),
        .DRAW_DATAW (1),
        .COORD_W    (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clear_req      (clear_req),
        .clear_done     (clear_done),
        .busy           (busy),
        .plot_valid     (plot_valid),
        .plot_ready     (plot_ready),
        .plot_x         (plot_x),
        .plot_y         (plot_y),
        .plot_color     (plot_color),
        .draw_addr_write(draw_addr_write),
        .draw_data_in   (draw_data_in),
        .draw_we        (draw_we),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: every accepted request is turned into a timeline of expected
    // outputs keyed by cycle number.
    int          cyc       = 0;
    int          clear_end = 0;
    int          exp_addr[int];
    int          exp_data[int];
    bit          exp_busy[int];
    bit          exp_done[int];
    logic [15:0] m_drop    = '0;
    bit          m_img[SIZE];
    bit          img_valid = 1'b1;
    int          m_a;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            if (cyc < clear_end) img_valid = 1'b0;
            clear_end = 0;
            m_drop    = '0;
            exp_addr.delete();
            exp_data.delete();
            exp_busy.delete();
            exp_done.delete();
        end else begin
            if (cyc >= clear_end && clear_req) begin
                for (int k = 0; k < int'(SIZE); k++) begin
                    exp_addr[cyc + 1 + k] = k;
                    exp_data[cyc + 1 + k] = 0;
                    exp_busy[cyc + 1 + k] = 1'b1;
                end
                exp_done[cyc + int'(SIZE) + 1] = 1'b1;
                clear_end = cyc + int'(SIZE) + 1;
                for (int i = 0; i < int'(SIZE); i++) m_img[i] = 1'b0;
                img_valid = 1'b1;
            end else if (cyc >= clear_end && plot_valid) begin
                if (int'(plot_x) < int'(W) && int'(plot_y) < int'(H)) begin
                    m_a = int'(plot_y) * int'(W) + int'(plot_x);
                    exp_addr[cyc + 1] = m_a;
                    exp_data[cyc + 1] = int'(plot_color);
                    m_img[m_a] = plot_color;
                end else if (m_drop != 16'hFFFF) begin
                    m_drop = m_drop + 16'd1;
                end
            end
            cyc++;
        end
    end

    // Compare process; fb is a framebuffer built only from the DUT's writes.
    bit fb[SIZE];
    int last_addr = 0;
    int last_data = 0;
    int bad;

    always @(negedge clk) begin
        if (reset) begin
            last_addr = 0;
            last_data = 0;
        end else begin
            if (exp_addr.exists(cyc)) begin
                check("draw_we", int'(draw_we), 1);
                check("draw_addr_write", int'(draw_addr_write), exp_addr[cyc]);
                check("draw_data_in", int'(draw_data_in), exp_data[cyc]);
                last_addr = exp_addr[cyc];
                last_data = exp_data[cyc];
            end else begin
                check("draw_we idle", int'(draw_we), 0);
                check("addr hold", int'(draw_addr_write), last_addr);
                check("data hold", int'(draw_data_in), last_data);
            end
            check("busy", int'(busy), int'(exp_busy.exists(cyc)));
            check("clear_done", int'(clear_done), int'(exp_done.exists(cyc)));
            check("drop_count", int'(drop_count), int'(m_drop));
            check("plot_ready", int'(plot_ready), int'(cyc >= clear_end && !clear_req));
            if (draw_we) fb[draw_addr_write] = draw_data_in;
            if (clear_done && img_valid) begin
                bad = 0;
                for (int i = 0; i < int'(SIZE); i++) if (fb[i] != m_img[i]) bad++;
                check("image after clear", bad, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plot(input int x, input int y, input int c);
        plot_valid = 1'b1;
        plot_x     = CW'(x);
        plot_y     = CW'(y);
        plot_color = 1'(c);
    endtask

    initial begin
        int n;
        int acc;
        int clears;
        int cycles;
        bit took;

        // Reset values
        #1 reset = 1'b1;
        #1;
        check("rst draw_we", int'(draw_we), 0);
        check("rst busy", int'(busy), 0);
        check("rst clear_done", int'(clear_done), 0);
        check("rst drop_count", int'(drop_count), 0);
        check("rst addr", int'(draw_addr_write), 0);
        tick();
        tick();
        reset = 1'b0;
        #1 check("ready after reset", int'(plot_ready), 1);

        // Single plot (3,2) -> address 2*8+3 = 19
        plot(3, 2, 1);
        #1 check("single ready", int'(plot_ready), 1);
        tick();
        plot_valid = 1'b0;
        check("single we", int'(draw_we), 1);
        check("single addr", int'(draw_addr_write), 19);
        check("single data", int'(draw_data_in), 1);
        tick();
        check("single we after", int'(draw_we), 0);

        // Off-screen plots
        plot(8, 0, 1);       tick(); check("offscreen we a", int'(draw_we), 0);
        plot(0, 4, 1);       tick(); check("offscreen we b", int'(draw_we), 0);
        plot(1023, 1023, 1); tick(); check("offscreen we c", int'(draw_we), 0);
        plot_valid = 1'b0;
        tick();
        check("drop_count 3", int'(drop_count), 3);

        // Drive the drop counter to saturation
        plot(9, 9, 0);
        for (int i = 0; i < 65532; i++) tick();
        check("drop_count max", int'(drop_count), 65535);
        tick();
        plot_valid = 1'b0;
        check("drop_count saturated", int'(drop_count), 65535);
        tick();

        // Clear sweep with ignored mid-sweep requests
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < int'(SIZE); k++) begin
            check("sweep we", int'(draw_we), 1);
            check("sweep addr", int'(draw_addr_write), k);
            check("sweep data", int'(draw_data_in), 0);
            check("sweep busy", int'(busy), 1);
            clear_req = (k == 5 || k == 20);
            #1 check("sweep ready", int'(plot_ready), 0);
            tick();
        end
        check("sweep done", int'(clear_done), 1);
        check("sweep busy end", int'(busy), 0);
        check("sweep we end", int'(draw_we), 0);
        check("sweep ready end", int'(plot_ready), 1);
        tick();
        check("sweep done pulse", int'(clear_done), 0);
        check("sweep no restart", int'(busy), 0);

        // Clear and plot requested together
        clear_req = 1'b1;
        plot(1, 1, 1);
        #1 check("simul ready", int'(plot_ready), 0);
        tick();
        clear_req = 1'b0;
        n = 0;
        while (!clear_done && n < 40) begin
            tick();
            n++;
        end
        check("simul clear_done", int'(clear_done), 1);
        check("simul done cycle", n, 32);
        #1 check("simul ready at done", int'(plot_ready), 1);
        tick();
        plot_valid = 1'b0;
        check("simul plot we", int'(draw_we), 1);
        check("simul plot addr", int'(draw_addr_write), 9);
        check("simul plot data", int'(draw_data_in), 1);
        tick();

        // Reset in the middle of a sweep
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("midclear addr", int'(draw_addr_write), 10);
        check("midclear busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("midreset we", int'(draw_we), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(clear_done), 0);
        check("midreset drop", int'(drop_count), 0);
        check("midreset addr", int'(draw_addr_write), 0);
        tick();
        reset = 1'b0;
        #1 check("midreset ready", int'(plot_ready), 1);
        n = 0;
        repeat (40) begin
            tick();
            if (clear_done) n++;
        end
        check("midreset no done", n, 0);

        // Random back-to-back stream with two clears
        acc    = 0;
        clears = 0;
        cycles = 0;
        plot(int'($urandom_range(9, 0)), int'($urandom_range(5, 0)), int'($urandom_range(1, 0)));
        while (acc < 100 && cycles < 3000) begin
            clear_req = ((acc == 30 && clears == 0) || (acc == 70 && clears == 1));
            if (clear_req) clears++;
            #1 took = plot_ready;
            tick();
            cycles++;
            if (took) begin
                acc++;
                plot(int'($urandom_range(9, 0)), int'($urandom_range(5, 0)), int'($urandom_range(1, 0)));
            end
        end
        clear_req  = 1'b0;
        plot_valid = 1'b0;
        check("stream accepted", acc, 100);
        check("stream clears", clears, 2);
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < int'(SIZE); i++) if (fb[i] != m_img[i]) bad++;
        check("final image", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
